mem_lsu: RTL and testbench

- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs and drives the MEM/WB register inputs.
- Performs data-bus transactions for LB/LBU/LH/LHU/LW/SB/SH/SW with a req/ack handshake and raises a stall request while an access is outstanding.
- Non-memory ops pass through with zero latency.
- Big-endian lane mapping.

---
 rtl/mem_lsu.sv | 210 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: big-endian byte lanes, registered req/ack data bus with ack timeout.
// Define MEM_ALIGN_CHK_EN to reject misaligned half/word accesses and add the align_err_o port.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_data_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_data_i,
    output logic        bus_err_o
`ifdef MEM_ALIGN_CHK_EN
    ,
    output logic        align_err_o
`endif
);

    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;

    // Abort fires on the edge that would bring the wait count up to TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} sz_e;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;

    logic        is_mem;
    logic        is_load;
    logic        is_signed;
    sz_e         size;
    logic        misaligned;
    logic [3:0]  sel_d;
    logic [31:0] sdata_d;
    logic [31:0] load_d;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin : decode
        is_mem    = 1'b1;
        is_load   = 1'b0;
        is_signed = 1'b0;
        size      = SZ_WORD;
        case (aluop_i)
            OP_LB:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_BYTE; end
            OP_LBU:  begin is_load = 1'b1; size = SZ_BYTE; end
            OP_LH:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_HALF; end
            OP_LHU:  begin is_load = 1'b1; size = SZ_HALF; end
            OP_LW:   is_load = 1'b1;
            OP_SB:   size = SZ_BYTE;
            OP_SH:   size = SZ_HALF;
            OP_SW:   size = SZ_WORD;
            default: is_mem = 1'b0;
        endcase
    end

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned = is_mem &&
                        ((size == SZ_HALF && mem_addr_i[0]) ||
                         (size == SZ_WORD && mem_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Lane 0 (sel bit 3) is the most significant byte: big-endian.
    always_comb begin : lanes
        sel_d   = 4'b1111;
        sdata_d = reg2_i;
        byte_v  = rdata_q[31:24];
        half_v  = rdata_q[31:16];
        load_d  = rdata_q;
        case (size)
            SZ_BYTE: begin
                sdata_d = {4{reg2_i[7:0]}};
                case (mem_addr_i[1:0])
                    2'b00:   begin sel_d = 4'b1000; byte_v = rdata_q[31:24]; end
                    2'b01:   begin sel_d = 4'b0100; byte_v = rdata_q[23:16]; end
                    2'b10:   begin sel_d = 4'b0010; byte_v = rdata_q[15:8];  end
                    default: begin sel_d = 4'b0001; byte_v = rdata_q[7:0];   end
                endcase
                load_d = is_signed ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            end
            SZ_HALF: begin
                sdata_d = {2{reg2_i[15:0]}};
                if (mem_addr_i[1]) begin
                    sel_d  = 4'b0011;
                    half_v = rdata_q[15:0];
                end else begin
                    sel_d  = 4'b1100;
                    half_v = rdata_q[31:16];
                end
                load_d = is_signed ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            rdata_q    <= 32'd0;
            bus_req_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_addr_o <= 32'd0;
            bus_sel_o  <= 4'd0;
            bus_data_o <= 32'd0;
            bus_err_o  <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (is_mem && !misaligned) begin
                        state_q    <= S_ACCESS;
                        cnt_q      <= 8'd0;
                        bus_req_o  <= 1'b1;
                        bus_we_o   <= !is_load;
                        bus_addr_o <= {mem_addr_i[31:2], 2'b00};
                        bus_sel_o  <= sel_d;
                        bus_data_o <= sdata_d;
                    end
                end
                S_ACCESS: begin
                    if (bus_ack_i) begin
                        rdata_q   <= bus_data_i;
                        bus_req_o <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q   <= 32'd0;
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    cnt_q   <= 8'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic align_err_d;

    always_comb begin : wb_out
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stallreq_o  = 1'b0;
        align_err_d = 1'b0;
        if (rst) begin
            wd_o    = 5'd0;
            wreg_o  = 1'b0;
            wdata_o = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mem) begin
                        wreg_o = 1'b0;
                        if (misaligned) align_err_d = 1'b1;
                        else            stallreq_o  = 1'b1;
                    end
                end
                S_ACCESS: begin
                    wreg_o     = 1'b0;
                    stallreq_o = 1'b1;
                end
                default: begin
                    if (is_load) wdata_o = load_d;
                    else if (is_mem) wreg_o = 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHK_EN
    assign align_err_o = align_err_d;
`else
    logic unused_align;
    assign unused_align = align_err_d;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, randomized transactions against
// a byte-arithmetic reference model, and hand-written timeout / reset / alignment sequences.
`timescale 1ns/1ps
module tb_mem_lsu;

    localparam int TIMEOUT = 16;

    localparam logic [7:0] OP_ADD = 8'b00100000;
    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_o;
    logic        bus_ack_i;
    logic [31:0] bus_data_i;
    logic        bus_err_o;
`ifdef MEM_ALIGN_CHK_EN
    logic        align_err_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .aluop_i    (aluop_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_sel_o  (bus_sel_o),
        .bus_data_o (bus_data_o),
        .bus_ack_i  (bus_ack_i),
        .bus_data_i (bus_data_i),
        .bus_err_o  (bus_err_o)
`ifdef MEM_ALIGN_CHK_EN
        ,
        .align_err_o(align_err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit op_is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic bit op_is_mem(input logic [7:0] op);
        return op_is_load(op) || (op inside {OP_SB, OP_SH, OP_SW});
    endfunction

    function automatic int op_size(input logic [7:0] op);
        if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
        if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
        return 4;
    endfunction

    // Byte offset of the accessed item inside the word, rounded down to its natural size.
    function automatic int m_off(input logic [7:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        return (int'(addr % 4) / sz) * sz;
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        return 4'(((1 << sz) - 1) << (4 - sz - m_off(op, addr)));
    endfunction

    function automatic logic [31:0] m_store(input logic [7:0] op, input logic [31:0] r);
        case (op_size(op))
            1:       return (r & 32'hFF) * 32'h01010101;
            2:       return (r & 32'hFFFF) * 32'h00010001;
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] d);
        int     sz    = op_size(op);
        int     shift = 8 * (4 - sz - m_off(op, addr));
        longint v     = (longint'(d) >> shift) & ((longint'(1) << (8 * sz)) - 1);
        if ((op == OP_LB || op == OP_LH) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic run_pass(input logic [7:0] op, input logic [31:0] wdata,
                            input logic [4:0] wd, input logic wr);
        @(negedge clk);
        aluop_i = op; wdata_i = wdata; wd_i = wd; wreg_i = wr; bus_ack_i = 1'b0;
        #1;
        check("pass wd_o", wd_o, wd);
        check("pass wreg_o", wreg_o, wr);
        check("pass wdata_o", wdata_o, wdata);
        check("pass stallreq_o", stallreq_o, 0);
        check("pass bus_req_o", bus_req_o, 0);
    endtask

    // waits < 0 means the bus never acks; otherwise ack arrives after `waits` idle ACCESS cycles.
    task automatic run_txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic [31:0] bdata, input int waits,
                           input logic [4:0] wd, input logic wr, input logic [3:0] exp_sel,
                           input logic [31:0] exp_bdo, input logic [31:0] exp_wdata);
        bit is_ld  = op_is_load(op);
        bit tmo    = (waits < 0) || (waits >= TIMEOUT);
        int len    = tmo ? TIMEOUT : waits + 1;
        int stalls = 0;
        int reqs   = 0;
        int wregs  = 0;
        @(negedge clk);
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = wr;
        wdata_i = 32'hC0DE0000 ^ addr; bus_ack_i = 1'b0; bus_data_i = $urandom;
        #1;
        check({tag, " idle stallreq"}, stallreq_o, 1);
        check({tag, " idle wreg_o"}, wreg_o, 0);
        check({tag, " idle bus_req"}, bus_req_o, 0);
        stalls += int'(stallreq_o);
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            bus_ack_i  = !tmo && (n == waits);
            bus_data_i = bus_ack_i ? bdata : $urandom;
            #1;
            if (n == 0) begin
                check({tag, " bus_addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
                check({tag, " bus_sel"}, bus_sel_o, exp_sel);
                check({tag, " bus_we"}, bus_we_o, !is_ld);
                if (!is_ld) check({tag, " bus_data"}, bus_data_o, exp_bdo);
            end
            stalls += int'(stallreq_o);
            reqs   += int'(bus_req_o);
            wregs  += int'(wreg_o);
        end
        @(negedge clk);
        bus_ack_i = 1'b0; bus_data_i = $urandom;
        #1;
        check({tag, " done stallreq"}, stallreq_o, 0);
        check({tag, " done bus_req"}, bus_req_o, 0);
        check({tag, " done bus_err"}, bus_err_o, tmo);
        check({tag, " done wd_o"}, wd_o, wd);
        check({tag, " done wreg_o"}, wreg_o, is_ld ? wr : 1'b0);
        if (is_ld) check({tag, " done wdata_o"}, wdata_o, exp_wdata);
        check({tag, " stall cycles"}, stalls, 1 + len);
        check({tag, " req cycles"}, reqs, len);
        check({tag, " access wreg"}, wregs, 0);
        @(negedge clk);
        aluop_i = OP_ADD;
        #1;
        check({tag, " after bus_err"}, bus_err_o, 0);
        check({tag, " after bus_req"}, bus_req_o, 0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] bdata;
        int          waits;
        logic [3:0]  sel;
        logic [31:0] bdo;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [31:0] bdata, input int waits, input logic [3:0] sel,
                           input logic [31:0] bdo, input logic [31:0] wdata);
        vec_t v;
        v.op = op; v.addr = addr; v.reg2 = reg2; v.bdata = bdata; v.waits = waits;
        v.sel = sel; v.bdo = bdo; v.wdata = wdata;
        vecs.push_back(v);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

        // Reset with a memory op presented: outputs forced low, bus registers cleared.
        rst = 1'b1; aluop_i = OP_LW; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hFFFF_FFFF;
        mem_addr_i = 32'h0; reg2_i = 32'h0; bus_ack_i = 1'b0; bus_data_i = 32'h0;
        @(negedge clk);
        #1;
        check("rst wd_o", wd_o, 0);
        check("rst wreg_o", wreg_o, 0);
        check("rst wdata_o", wdata_o, 0);
        check("rst stallreq", stallreq_o, 0);
        check("rst bus_req", bus_req_o, 0);
        check("rst bus_we", bus_we_o, 0);
        check("rst bus_addr", bus_addr_o, 0);
        check("rst bus_sel", bus_sel_o, 0);
        check("rst bus_data", bus_data_o, 0);
        check("rst bus_err", bus_err_o, 0);
        @(negedge clk);
        rst = 1'b0; aluop_i = OP_ADD;

        run_pass(OP_ADD, 32'h12345678, 5'd3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] op;
            do op = 8'($urandom); while (op_is_mem(op));
            run_pass(op, $urandom, 5'($urandom), 1'($urandom));
        end

        add_vec(OP_LB,  32'h101, 32'h0,        32'h11F03344, 0,  4'b0100, 32'h0,        32'hFFFFFFF0);
        add_vec(OP_SH,  32'h202, 32'hAAAA5566, 32'h0,        3,  4'b0011, 32'h55665566, 32'h0);
        add_vec(OP_LW,  32'h300, 32'h0,        32'h0,        -1, 4'b1111, 32'h0,        32'h0);
        add_vec(OP_LHU, 32'h400, 32'h0,        32'h80017F00, 1,  4'b1100, 32'h0,        32'h00008001);
        add_vec(OP_LH,  32'h402, 32'h0,        32'h12348765, 2,  4'b0011, 32'h0,        32'hFFFF8765);
        add_vec(OP_LBU, 32'h503, 32'h0,        32'hAABBCC99, 0,  4'b0001, 32'h0,        32'h00000099);
        add_vec(OP_SB,  32'h600, 32'h12345678, 32'h0,        0,  4'b1000, 32'h78787878, 32'h0);
        add_vec(OP_SW,  32'h704, 32'hDEADBEEF, 32'h0,        TIMEOUT - 1, 4'b1111, 32'hDEADBEEF, 32'h0);
        add_vec(OP_LB,  32'h100, 32'h0,        32'h80000000, 0,  4'b1000, 32'h0,        32'hFFFFFF80);
        add_vec(OP_LBU, 32'h102, 32'h0,        32'h00007F00, 1,  4'b0010, 32'h0,        32'h0000007F);
`ifndef MEM_ALIGN_CHK_EN
        add_vec(OP_LW,  32'h302, 32'h0,        32'hCAFEF00D, 0,  4'b1111, 32'h0,        32'hCAFEF00D);
        add_vec(OP_LH,  32'h401, 32'h0,        32'h9ABC1234, 0,  4'b1100, 32'h0,        32'hFFFF9ABC);
`endif
        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].bdata,
                    vecs[i].waits, 5'(i + 1), 1'b1, vecs[i].sel, vecs[i].bdo, vecs[i].wdata);

        for (int i = 0; i < 40; i++) begin
            logic [7:0]  op    = ops[$urandom_range(0, 7)];
            logic [31:0] addr  = $urandom;
            logic [31:0] reg2  = $urandom;
            logic [31:0] bdata = $urandom;
            int          r     = int'($urandom_range(0, 11));
            int          waits = (r == 11) ? -1 : (r == 10) ? TIMEOUT - 1 : r % 5;
`ifdef MEM_ALIGN_CHK_EN
            addr = addr & ~32'(op_size(op) - 1);
`endif
            run_txn($sformatf("rnd%0d", i), op, addr, reg2, bdata, waits, 5'($urandom),
                    1'($urandom), m_sel(op, addr), m_store(op, reg2),
                    (waits < 0) ? 32'h0 : m_load(op, addr, bdata));
        end

        // Reset in the second ACCESS cycle, followed by a late ack.
        @(negedge clk);
        aluop_i = OP_LW; mem_addr_i = 32'h800; wd_i = 5'd9; wreg_i = 1'b1; bus_ack_i = 1'b0;
        @(negedge clk);
        #1;
        check("mid access bus_req", bus_req_o, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid rst stallreq", stallreq_o, 0);
        check("mid rst wreg_o", wreg_o, 0);
        check("mid rst wd_o", wd_o, 0);
        check("mid rst wdata_o", wdata_o, 0);
        @(negedge clk);
        rst = 1'b0; aluop_i = OP_ADD; wdata_i = 32'h0BADF00D; wd_i = 5'd4; wreg_i = 1'b1;
        bus_ack_i = 1'b1; bus_data_i = 32'h55AA55AA;
        #1;
        check("post rst bus_req", bus_req_o, 0);
        check("post rst stallreq", stallreq_o, 0);
        check("post rst wdata_o", wdata_o, 32'h0BADF00D);
        @(negedge clk);
        #1;
        check("late ack bus_req", bus_req_o, 0);
        check("late ack bus_err", bus_err_o, 0);
        check("late ack stallreq", stallreq_o, 0);
        bus_ack_i = 1'b0;

`ifdef MEM_ALIGN_CHK_EN
        @(negedge clk);
        aluop_i = OP_LW; mem_addr_i = 32'h302; wd_i = 5'd5; wreg_i = 1'b1;
        #1;
        check("align err", align_err_o, 1);
        check("align stallreq", stallreq_o, 0);
        check("align wreg_o", wreg_o, 0);
        @(negedge clk);
        aluop_i = OP_ADD;
        #1;
        check("align bus_req", bus_req_o, 0);
        check("align err clear", align_err_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
